// File: rtl/stream_word_unpacker_pkg.sv
// Shared widths, derived lane geometry and FSM encoding for the word-to-key unpacker.
package stream_word_unpacker_pkg;

  localparam int SORTW_DEF = 32;
  localparam int DRAMW_DEF = 64;
  localparam int ELEMS_DEF = DRAMW_DEF / SORTW_DEF;

  // Counter width that stays at least one bit for degenerate sizes.
  function automatic int lane_bits(input int elems);
    return (elems > 1) ? $clog2(elems) : 1;
  endfunction

  localparam int LANE_W_DEF     = lane_bits(ELEMS_DEF);
  localparam int UNIT_ELEMS_DEF = 4 * ELEMS_DEF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    EMIT  = 2'd1,
    STALL = 2'd2
  } state_t;

endpackage

// File: rtl/stream_word_unpacker_wbuf.sv
// Two-entry word FIFO: head is combinational from storage, full/empty/count from registered state only.
module unpack_wbuf #(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         enq,
  input  logic         deq,
  input  logic [W-1:0] din,
  output logic [W-1:0] head,
  output logic         empty,
  output logic         full,
  output logic [1:0]   count
);

  logic [W-1:0] mem [2];
  logic         wptr;
  logic         rptr;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr  <= 1'b0;
      rptr  <= 1'b0;
      count <= 2'd0;
    end else begin
      if (enq) wptr <= ~wptr;
      if (deq) rptr <= ~rptr;
      case ({enq, deq})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Storage is not reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (enq) mem[wptr] <= din;
  end

  assign head  = mem[rptr];
  assign empty = (count == 2'd0);
  assign full  = count[1];

endmodule

// File: rtl/stream_word_unpacker.sv
// Serialises DRAMW words into SORTW keys (lane 0 first), one key per cycle, with per-unit last flag.
// Optional STREAM_UNPACK_ORDER_CHECK_EN adds a sticky in-unit descending-key detector on SORT_ERR.
module stream_word_unpacker
  import stream_word_unpacker_pkg::*;
#(
  parameter int SORTW      = SORTW_DEF,
  parameter int DRAMW      = DRAMW_DEF,
  parameter int UNIT_ELEMS = UNIT_ELEMS_DEF
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [DRAMW-1:0] DIN,
  input  logic             DINV,
  output logic             DIN_RDY,
  output logic [SORTW-1:0] DOUT,
  output logic             DOUT_ENQ,
  input  logic             DOUT_FULL,
  output logic             DOUT_LAST,
  output logic             SORT_ERR
);

  localparam int ELEMS  = DRAMW / SORTW;
  localparam int LANE_W = lane_bits(ELEMS);
  localparam int UCNT_W = lane_bits(UNIT_ELEMS);

  logic [DRAMW-1:0]  head;
  logic              buf_empty;
  logic              buf_full;
  logic [1:0]        buf_count;
  logic              accept;
  logic              issue;
  logic              pop;
  logic [LANE_W-1:0] lane;
  logic              lane_last;
  logic [UCNT_W-1:0] ucnt;
  logic              ucnt_last;
  logic [SORTW-1:0]  key;
  state_t            state_q;
  state_t            state_d;

  assign DIN_RDY   = !buf_full;
  assign accept    = DINV && !buf_full;
  assign issue     = !buf_empty && !DOUT_FULL;
  assign lane_last = (lane == LANE_W'(ELEMS - 1));
  assign ucnt_last = (ucnt == UCNT_W'(UNIT_ELEMS - 1));
  assign pop       = issue && lane_last;

  unpack_wbuf #(.W(DRAMW)) u_wbuf (
    .clk   (CLK),
    .rst_n (RST),
    .enq   (accept),
    .deq   (pop),
    .din   (DIN),
    .head  (head),
    .empty (buf_empty),
    .full  (buf_full),
    .count (buf_count)
  );

  always_comb begin
    key = '0;
    for (int k = 0; k < ELEMS; k++) begin
      if (lane == LANE_W'(k)) key = head[k*SORTW +: SORTW];
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q <= IDLE;
      lane    <= '0;
      ucnt    <= '0;
    end else begin
      state_q <= state_d;
      if (issue) begin
        lane <= lane_last ? '0 : lane + LANE_W'(1);
        ucnt <= ucnt_last ? '0 : ucnt + UCNT_W'(1);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = EMIT;
      EMIT: begin
        if (DOUT_FULL)
          state_d = STALL;
        else if (pop && buf_count == 2'd1 && !accept)
          state_d = IDLE;
      end
      STALL:   if (!DOUT_FULL) state_d = EMIT;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      DOUT      <= '0;
      DOUT_ENQ  <= 1'b0;
      DOUT_LAST <= 1'b0;
    end else begin
      DOUT_ENQ  <= issue;
      DOUT_LAST <= issue && ucnt_last;
      if (issue) DOUT <= key;
    end
  end

`ifdef STREAM_UNPACK_ORDER_CHECK_EN
  logic [SORTW-1:0] prev_key;
  logic             sort_err_q;

  // The first key of a unit (ucnt == 0) starts a fresh ordering run.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      prev_key   <= '0;
      sort_err_q <= 1'b0;
    end else if (issue) begin
      prev_key <= key;
      if (ucnt != '0 && key < prev_key) sort_err_q <= 1'b1;
    end
  end

  assign SORT_ERR = sort_err_q;
`else
  assign SORT_ERR = 1'b0;
`endif

endmodule

// File: tb/tb_stream_word_unpacker.sv
// Directed bench: per-cycle vector table plus stream sequences for reset-mid-word and order checking.
module tb_stream_word_unpacker;

  logic        CLK = 1'b0;
  logic        RST;
  logic [63:0] DIN;
  logic        DINV;
  logic        DIN_RDY;
  logic [31:0] DOUT;
  logic        DOUT_ENQ;
  logic        DOUT_FULL;
  logic        DOUT_LAST;
  logic        SORT_ERR;

  int total = 0;
  int bad   = 0;

  stream_word_unpacker #(.SORTW(32), .DRAMW(64), .UNIT_ELEMS(8)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .DIN       (DIN),
    .DINV      (DINV),
    .DIN_RDY   (DIN_RDY),
    .DOUT      (DOUT),
    .DOUT_ENQ  (DOUT_ENQ),
    .DOUT_FULL (DOUT_FULL),
    .DOUT_LAST (DOUT_LAST),
    .SORT_ERR  (SORT_ERR)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        rst;
    logic        dinv;
    logic        full;
    logic [63:0] din;
    logic        chk;
    logic        rdy;
    logic        enq;
    logic [31:0] dout;
    logic        last;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [63:0] w(input int hi, input int lo);
    return {32'(hi), 32'(lo)};
  endfunction

  function automatic vec_t v(input logic rst, input logic dinv, input logic full, input logic [63:0] din,
                             input logic chk, input logic rdy, input logic enq, input int dout, input logic last);
    vec_t r;
    r.rst = rst; r.dinv = dinv; r.full = full; r.din = din;
    r.chk = chk; r.rdy = rdy; r.enq = enq; r.dout = 32'(dout); r.last = last;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    RST = 1'b0; DINV = 1'b0; DIN = '0; DOUT_FULL = 1'b0;
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    RST = 1'b1;
  endtask

  logic [31:0] skeys   [16];
  logic [31:0] got_key [16];
  logic        got_last[16];
  logic        got_err [16];
  int          got;

  // Pushes nw words built from skeys (lane 0 = lower key), holding a word while DIN_RDY is low.
  task automatic stream(input int nw);
    int   widx;
    logic acc;
    widx = 0;
    got  = 0;
    for (int cyc = 0; cyc < 200 && got < 2*nw; cyc++) begin
      DINV = (widx < nw);
      if (widx < nw) DIN = {skeys[2*widx+1], skeys[2*widx]};
      else           DIN = '0;
      @(negedge CLK);
      if (DOUT_ENQ) begin
        got_key[got]  = DOUT;
        got_last[got] = DOUT_LAST;
        got_err[got]  = SORT_ERR;
        got++;
      end
      acc = DINV && DIN_RDY;
      @(posedge CLK); #1;
      if (acc) widx++;
    end
    DINV = 1'b0;
    check($sformatf("stream_key_count_%0dw", nw), 32'(got), 32'(2*nw));
  endtask

  task automatic check_stream(input string tag);
    logic exp_err;
    exp_err = 1'b0;
    for (int i = 0; i < got; i++) begin
`ifdef STREAM_UNPACK_ORDER_CHECK_EN
      if (i % 8 != 0 && skeys[i] < skeys[i-1]) exp_err = 1'b1;
`endif
      check($sformatf("%s_key%0d", tag, i), got_key[i], skeys[i]);
      check($sformatf("%s_last%0d", tag, i), 32'(got_last[i]), 32'(i % 8 == 7));
      check($sformatf("%s_err%0d", tag, i), 32'(got_err[i]), 32'(exp_err));
    end
  endtask

  initial begin
    RST = 1'b0; DINV = 1'b0; DIN = '0; DOUT_FULL = 1'b0;

    // Single word: two keys two cycles after acceptance.
    tbl.push_back(v(0,0,0,64'h0,      0, 0,0,0,0));
    tbl.push_back(v(0,0,0,64'h0,      1, 1,0,0,0));
    tbl.push_back(v(1,1,0,w(2,1),     1, 1,0,0,0));
    tbl.push_back(v(1,0,0,64'h0,      1, 1,0,0,0));
    tbl.push_back(v(1,0,0,64'h0,      1, 1,1,1,0));
    tbl.push_back(v(1,0,0,64'h0,      1, 1,1,2,0));
    tbl.push_back(v(1,0,0,64'h0,      1, 1,0,2,0));
    // Four words back to back, upstream holding a word while not ready.
    tbl.push_back(v(0,0,0,64'h0,      0, 0,0,0,0));
    tbl.push_back(v(0,0,0,64'h0,      1, 1,0,0,0));
    tbl.push_back(v(1,1,0,w(2,1),     1, 1,0,0,0));
    tbl.push_back(v(1,1,0,w(4,3),     1, 1,0,0,0));
    tbl.push_back(v(1,1,0,w(6,5),     1, 0,1,1,0));
    tbl.push_back(v(1,1,0,w(6,5),     1, 1,1,2,0));
    tbl.push_back(v(1,1,0,w(8,7),     1, 0,1,3,0));
    tbl.push_back(v(1,1,0,w(8,7),     1, 1,1,4,0));
    tbl.push_back(v(1,0,0,64'h0,      1, 0,1,5,0));
    tbl.push_back(v(1,0,0,64'h0,      1, 1,1,6,0));
    tbl.push_back(v(1,0,0,64'h0,      1, 1,1,7,0));
    tbl.push_back(v(1,0,0,64'h0,      1, 1,1,8,1));
    tbl.push_back(v(1,0,0,64'h0,      1, 1,0,8,0));
    // Downstream full for three cycles after the first key.
    tbl.push_back(v(0,0,0,64'h0,      0, 0,0,0,0));
    tbl.push_back(v(0,0,0,64'h0,      1, 1,0,0,0));
    tbl.push_back(v(1,1,0,w(2,1),     1, 1,0,0,0));
    tbl.push_back(v(1,1,0,w(4,3),     1, 1,0,0,0));
    tbl.push_back(v(1,0,1,64'h0,      1, 0,1,1,0));
    tbl.push_back(v(1,0,1,64'h0,      1, 0,0,1,0));
    tbl.push_back(v(1,0,1,64'h0,      1, 0,0,1,0));
    tbl.push_back(v(1,0,0,64'h0,      1, 0,0,1,0));
    tbl.push_back(v(1,0,0,64'h0,      1, 1,1,2,0));
    tbl.push_back(v(1,0,0,64'h0,      1, 1,1,3,0));
    tbl.push_back(v(1,0,0,64'h0,      1, 1,1,4,0));
    tbl.push_back(v(1,0,0,64'h0,      1, 1,0,4,0));

    for (int i = 0; i < tbl.size(); i++) begin
      RST = tbl[i].rst; DINV = tbl[i].dinv; DOUT_FULL = tbl[i].full; DIN = tbl[i].din;
      @(negedge CLK);
      if (tbl[i].chk) begin
        check($sformatf("row%0d_rdy", i),  32'(DIN_RDY),   32'(tbl[i].rdy));
        check($sformatf("row%0d_enq", i),  32'(DOUT_ENQ),  32'(tbl[i].enq));
        check($sformatf("row%0d_dout", i), DOUT,           tbl[i].dout);
        check($sformatf("row%0d_last", i), 32'(DOUT_LAST), 32'(tbl[i].last));
        check($sformatf("row%0d_err", i),  32'(SORT_ERR),  32'd0);
      end
      @(posedge CLK); #1;
    end

    // Reset while lane 1 of a buffered word is pending.
    do_reset();
    DIN = w(32'h22, 32'h11); DINV = 1'b1;
    @(posedge CLK); #1;
    DINV = 1'b0;
    @(posedge CLK); #1;
    RST = 1'b0;
    @(negedge CLK);
    check("midrst_pre_enq",  32'(DOUT_ENQ), 32'd1);
    check("midrst_pre_dout", DOUT, 32'h11);
    @(posedge CLK); #1;
    RST = 1'b1;
    @(negedge CLK);
    check("midrst_enq",  32'(DOUT_ENQ),  32'd0);
    check("midrst_dout", DOUT,           32'd0);
    check("midrst_last", 32'(DOUT_LAST), 32'd0);
    check("midrst_rdy",  32'(DIN_RDY),   32'd1);
    check("midrst_err",  32'(SORT_ERR),  32'd0);
    @(posedge CLK); #1;
    for (int i = 0; i < 16; i++) skeys[i] = 32'h31 + 32'(i);
    stream(4);
    check_stream("postrst");

    // Ordered within units, descending only across the unit boundary (9 then 1).
    do_reset();
    skeys = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7, 32'd9,
              32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7, 32'd8};
    stream(8);
    check_stream("xunit");

    // 5 followed by 3 inside one unit.
    do_reset();
    skeys = '{32'd1, 32'd5, 32'd3, 32'd4, 32'd6, 32'd7, 32'd8, 32'd9,
              32'd10, 32'd11, 32'd12, 32'd13, 32'd14, 32'd15, 32'd16, 32'd17};
    stream(4);
    check_stream("inunit");
    repeat (2) @(posedge CLK);
    #1;
`ifdef STREAM_UNPACK_ORDER_CHECK_EN
    check("err_sticky", 32'(SORT_ERR), 32'd1);
`else
    check("err_sticky", 32'(SORT_ERR), 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
